// File: rtl/uc.sv
// Control unit: combinational instruction decode over a RUN/TRAP state, a 4-bit loop counter and an optional zero flag.
// Build option: define UC_ZFLAG_REG_EN to make conditional jumps test a registered ALU zero flag instead of the live z input.
module uc (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic [2:0] op,
  output logic       trap,
  output logic [3:0] lc
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] TRAP = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] lc_q, lc_d;
  logic       zsel;

  logic is_li, is_alu, is_setlc, is_j, is_jz, is_jnz, is_djnz, is_illegal;
  logic in_run;

  assign is_li      = (opcode[5:2] == 4'b0001);
  assign is_alu     = (opcode[5:3] == 3'b001);
  assign is_setlc   = (opcode[5:4] == 2'b01);
  assign is_j       = (opcode == 6'b100000);
  assign is_jz      = (opcode == 6'b100001);
  assign is_jnz     = (opcode == 6'b100010);
  assign is_djnz    = (opcode == 6'b100011);
  // 100100..111111: upper bit set with anything beyond the four branch encodings
  assign is_illegal = opcode[5] & (opcode[4:2] != 3'b000);
  assign in_run     = (state_q == RUN);

`ifdef UC_ZFLAG_REG_EN
  logic zf_q, zf_d;

  always_comb begin
    zf_d = zf_q;
    if (in_run && is_alu) begin
      zf_d = z;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zf_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
    end
  end

  assign zsel = zf_q;
`else
  assign zsel = z;
`endif

  // In TRAP all architectural state is frozen until reset.
  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    if (in_run) begin
      if (is_illegal) begin
        state_d = TRAP;
      end
      if (is_setlc) begin
        lc_d = opcode[3:0];
      end
      if (is_djnz && (lc_q != 4'd0)) begin
        lc_d = lc_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      lc_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      lc_q    <= lc_d;
    end
  end

  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    op    = 3'b000;
    trap  = ~in_run;
    if (is_li) begin
      we3   = 1'b1;
      s_inm = 1'b1;
    end
    if (is_alu) begin
      we3 = 1'b1;
      op  = opcode[2:0];
    end
    if (is_j) begin
      s_inc = 1'b0;
    end
    if (is_jz) begin
      s_inc = ~zsel;
    end
    if (is_jnz) begin
      s_inc = zsel;
    end
    if (is_djnz) begin
      s_inc = (lc_q == 4'd0);
    end
    if (!in_run) begin
      we3 = 1'b0;
    end
    // Reset overrides the decode combinationally, not just at the next edge.
    if (!reset) begin
      s_inc = 1'b1;
      s_inm = 1'b0;
      we3   = 1'b0;
      op    = 3'b000;
      trap  = 1'b0;
    end
  end

  assign lc = lc_q;

endmodule

// File: tb/tb_uc.sv
// Scoreboard bench for uc: stimulus pushes model-predicted outputs, a negedge monitor pops and compares.
module tb_uc;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       z;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic [2:0] op;
  logic       trap;
  logic [3:0] lc;

  uc dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .z      (z),
    .s_inc  (s_inc),
    .s_inm  (s_inm),
    .we3    (we3),
    .op     (op),
    .trap   (trap),
    .lc     (lc)
  );

  typedef struct packed {
    logic [5:0] opc;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic [2:0] op;
    logic       trap;
    logic [3:0] lc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // Reference model state
  bit m_trap = 1'b0;
  int m_lc   = 0;
`ifdef UC_ZFLAG_REG_EN
  bit m_zf   = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: txn %0d got %0d required %0d", name, n_txn, act, req);
    end
  endtask

  // Predict the outputs for this cycle, queue them, then advance the model past the coming edge.
  task automatic drive(input logic [5:0] opc, input logic zin, input logic rst);
    exp_t e;
    int   v;
    bit   zs;
    @(posedge clk);
    #1;
    opcode = opc;
    z      = zin;
    reset  = rst;
    v      = int'(opc);
`ifdef UC_ZFLAG_REG_EN
    zs = m_zf;
`else
    zs = zin;
`endif
    if (!rst) begin
      m_trap = 1'b0;
      m_lc   = 0;
`ifdef UC_ZFLAG_REG_EN
      m_zf   = 1'b0;
`endif
    end
    e.opc   = opc;
    e.s_inc = 1'b1;
    e.s_inm = 1'b0;
    e.we3   = 1'b0;
    e.op    = 3'd0;
    e.trap  = 1'b0;
    e.lc    = 4'(m_lc);
    if (rst) begin
      if (v >= 4 && v <= 7) begin
        e.we3 = 1'b1;
        e.s_inm = 1'b1;
      end else if (v >= 8 && v <= 15) begin
        e.we3 = 1'b1;
        e.op  = 3'(v % 8);
      end else if (v == 32) begin
        e.s_inc = 1'b0;
      end else if (v == 33) begin
        e.s_inc = !zs;
      end else if (v == 34) begin
        e.s_inc = zs;
      end else if (v == 35) begin
        e.s_inc = (m_lc == 0);
      end
      if (m_trap) begin
        e.trap = 1'b1;
        e.we3  = 1'b0;
      end
      if (!m_trap) begin
        if (v >= 36) m_trap = 1'b1;
        else if (v >= 16 && v <= 31) m_lc = v % 16;
        else if (v == 35 && m_lc > 0) m_lc = m_lc - 1;
`ifdef UC_ZFLAG_REG_EN
        if (v >= 8 && v <= 15) m_zf = zin;
`endif
      end
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_txn++;
      $display("txn %0d reset=%b opcode=%b z=%b -> s_inc=%b s_inm=%b we3=%b op=%b trap=%b lc=%0d",
               n_txn, reset, e.opc, z, s_inc, s_inm, we3, op, trap, lc);
      chk("s_inc", int'(s_inc), int'(e.s_inc));
      chk("s_inm", int'(s_inm), int'(e.s_inm));
      chk("we3",   int'(we3),   int'(e.we3));
      chk("op",    int'(op),    int'(e.op));
      chk("trap",  int'(trap),  int'(e.trap));
      chk("lc",    int'(lc),    int'(e.lc));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [5:0] ropc;
    reset  = 1'b1;
    opcode = 6'd0;
    z      = 1'b0;
    #2 reset = 1'b0;

    // Reset masks an ALU opcode; release lets it through
    drive(6'b001010, 1'b0, 1'b0);
    drive(6'b001010, 1'b0, 1'b1);

    // SETLC 3 then DJNZ x5
    drive(6'b010011, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(6'b100011, 1'b0, 1'b1);
    drive(6'b000000, 1'b0, 1'b1);

    // Zero source selection: ALU with z=1, JZ with z=0
    drive(6'b001000, 1'b1, 1'b1);
    drive(6'b100001, 1'b0, 1'b1);
    drive(6'b100010, 1'b1, 1'b1);

    // Illegal opcode enters TRAP; writes suppressed, jumps still steer
    drive(6'b010010, 1'b0, 1'b1);
    drive(6'b110000, 1'b0, 1'b1);
    drive(6'b001001, 1'b0, 1'b1);
    drive(6'b100000, 1'b0, 1'b1);
    drive(6'b100011, 1'b0, 1'b1);
    drive(6'b010111, 1'b0, 1'b1);
    drive(6'b100011, 1'b0, 1'b1);

    // Reset pulse between edges clears TRAP at once
    drive(6'b100000, 1'b0, 1'b0);
    drive(6'b000100, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) ropc = 6'($urandom_range(36, 63));
      else       ropc = 6'($urandom_range(0, 35));
      drive(ropc, 1'($urandom_range(0, 1)), (r >= 97) ? 1'b0 : 1'b1);
    end
    drive(6'b000000, 1'b0, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d transactions left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uc.md
UC -- requirements
Module: uc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock shared with the datapath.
REQ-003 Port: reset  input  1  asynchronous active-low reset; 0 = in reset.
REQ-004 Port: opcode  input  6  opcode field of the current instruction from the datapath.
REQ-005 Port: z  input  1  live ALU zero flag from the datapath.
REQ-006 Port: s_inc  output  1  PC mux select; 1 = PC+1, 0 = jump target.
REQ-007 Port: s_inm  output  1  write-data mux select; 1 = immediate, 0 = ALU result.
REQ-008 Port: we3  output  1  register-file write enable.
REQ-009 Port: op  output  3  ALU operation select.
REQ-010 Port: trap  output  1  sticky illegal-opcode indicator.
REQ-011 Port: lc  output  4  current loop-counter value, for debug and bench observation.

Function
REQ-012 The decode SHALL be combinational from opcode and registered state; zero added latency, so the datapath acts in the same cycle.
REQ-013 Defaults, applied unless overridden below: s_inc=1, s_inm=0, we3=0, op=000.
REQ-014 000000 NOP: defaults only.
REQ-015 0001xx LI: we3=1, s_inm=1.
REQ-016 001ooo ALU: we3=1, s_inm=0, op=opcode[2:0]; zf<=z at the clock edge.
REQ-017 01cccc SETLC: lc<=opcode[3:0] at the clock edge.
REQ-018 100000 J: s_inc=0.
REQ-019 100001 JZ: s_inc=~zsel, where zsel is the zero source selected in Configuration.
REQ-020 100010 JNZ: s_inc=zsel.
REQ-021 100011 DJNZ when lc!=0: s_inc=0 and lc<=lc-1 at the edge.
REQ-022 100011 DJNZ when lc==0: s_inc=1 and lc stays 0 (no wrap to 15).
REQ-023 All other opcodes (100100-111111) SHALL be illegal: defaults only, plus the state transition in REQ-024.
REQ-024 FSM states are RUN and TRAP: RUN -> TRAP on the edge where an illegal opcode is decoded; TRAP -> TRAP until reset.
REQ-025 In TRAP:
- trap=1 and we3 forced 0 for every opcode;
- zf and lc frozen;
- J/JZ/JNZ/DJNZ still steer s_inc, using the frozen values.
REQ-026 In RUN, trap=0.
REQ-027 The illegal opcode's own cycle SHALL output defaults with trap=0; trap rises on the following cycle.
REQ-028 lc arithmetic SHALL be 4-bit unsigned.

Reset
REQ-029 While reset=0: state=RUN, zf=0, lc=0.
REQ-030 While reset=0, outputs are forced regardless of opcode: s_inc=1, s_inm=0, we3=0, op=000, trap=0.
REQ-031 Asserting reset mid-operation, including in TRAP, SHALL clear all state immediately without waiting for a clock edge.
REQ-032 Deassertion SHALL take effect at the first rising clk edge after reset returns to 1.

Configuration
REQ-033 With macro UC_ZFLAG_REG_EN defined: zsel=zf, the registered flag updated only by ALU instructions.
REQ-034 With UC_ZFLAG_REG_EN undefined: zsel=z (live input); the zf register and its update logic SHALL be omitted.

Verification
REQ-035 Reset=0 with opcode=001010 -> we3=0, s_inc=1, op=000, lc=0, trap=0; release reset -> we3=1, op=010.
REQ-036 SETLC 010011, then DJNZ repeated 5 cycles -> s_inc=0,0,0,1,1 and lc=2,1,0,0,0 after each edge.
REQ-037 With UC_ZFLAG_REG_EN defined: ALU with z=1, then JZ with z=0 -> JZ s_inc=0. Without the macro, the same stimulus -> s_inc=1.
REQ-038 Opcode 110000, then ALU 001001 -> trap=0 in the illegal cycle, trap=1 next cycle, we3=0 on the ALU instruction, J 100000 still gives s_inc=0.
REQ-039 In TRAP, pulse reset=0 between clock edges -> trap=0 immediately; next LI 000100 -> we3=1, s_inm=1.
